shared_line_arbiter: RTL and testbench
======================================

Name: shared_line_arbiter

Overview:
- Round-robin arbiter for one shared bidirectional line (inout net) with N_REQ potential drivers.
- Grants exactly one driver at a time.
- Inserts mandatory all-released turnaround cycles between owners, so two drivers never fight over the net.
- Each requester's tristate enable is taken directly from its grant bit.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- TURN_CYC, 1, dead cycles with no grant after every release (1..7).
- MAX_HOLD, 16, maximum consecutive granted cycles per ownership (2..255).

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  synchronous reset, active-low.
- req  input  N_REQ  request per driver; level, held until done.
- grant  output  N_REQ  one-hot or zero; bit i enables driver i's tristate.
- owner_id  output  max(1,clog2(N_REQ))  index of current owner; valid while bus_busy=1.
- bus_busy  output  1  1 while any grant bit is set.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - grant=0, owner_id=0, bus_busy=0, timeout=0.
  - State=IDLE, rr_ptr=0, hold_cnt=0, turn_cnt=0.
  - Applies mid-grant too: grant drops on the reset edge, with no turnaround owed afterwards.
- All outputs are registered. No combinational path from req to grant.
- States: IDLE, OWN, TURN.
- IDLE:
  - If req!=0 at an edge, pick the first set bit searching from rr_ptr upward, with wrap (rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ...).
  - On that same edge: grant[w]=1, owner_id=w, bus_busy=1, hold_cnt=1, go to OWN.
  - Latency: req first high before edge k -> grant visible after edge k.
  - If req=0, stay in IDLE.
- OWN, owner w:
  - Each edge with req[w]=1 and hold_cnt<MAX_HOLD: hold_cnt++.
  - If req[w]=0 at an edge (normal release): grant=0, bus_busy=0, rr_ptr=(w+1) mod N_REQ, turn_cnt=1, go to TURN.
  - If req[w]=1 and hold_cnt==MAX_HOLD at an edge (forced release): same actions as a normal release, plus timeout=1 for exactly one cycle.
  - Grant width therefore never exceeds MAX_HOLD cycles.
  - Requests from other bits while in OWN are ignored; they are never pre-empted and never lost while held.
- TURN:
  - grant=0 for exactly TURN_CYC cycles.
  - At each edge: if turn_cnt<TURN_CYC then turn_cnt++; else arbitrate as in IDLE on that same edge (grant a winner, or go to IDLE if req=0).
  - So minimum gap between grant falling and the next grant rising is TURN_CYC cycles.
- Fairness: rr_ptr advances past the previous owner. A timed-out owner that keeps req high is lowest priority in the next round and may win only if it is the sole requester.
- owner_id holds its last value when bus_busy=0.
- A req bit deasserting during TURN or IDLE has no effect.
- Invariant: popcount(grant)<=1 on every cycle, including the reset cycle.

Optional Feature:
- Macro SHARED_LINE_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit).
  - While in OWN with lock=1, the MAX_HOLD limit is suspended: hold_cnt saturates at MAX_HOLD, no forced release, no timeout.
  - If lock deasserts while hold_cnt==MAX_HOLD and req[w]=1, the forced release and timeout pulse occur on the next edge.
  - lock is ignored outside OWN.
- When undefined: no lock port; MAX_HOLD is always enforced.

Test Plan:
- Reset then single requester: N_REQ=4, req=0010 from cycle 3 -> grant=0010 and owner_id=1 from cycle 4. Drop req at cycle 8 -> grant=0000 from cycle 9, bus_busy=0 for TURN_CYC=1 cycle.
- Round-robin: req=1111 held, each owner drops req after 2 granted cycles -> grant sequence 0001,0010,0100,1000,0001, with exactly 1 zero cycle between owners. grant is one-hot or zero on every cycle.
- Timeout: MAX_HOLD=16, req=0100 held forever -> grant=0100 for exactly 16 cycles, timeout pulses once on the release edge, then 1 turnaround cycle, then grant=0100 again (sole requester).
- Turnaround length: TURN_CYC=3, req=0011 both held, owner drops -> grant=0000 for exactly 3 cycles, then grant=0010.
- Reset mid-grant: rst_n=0 for 1 cycle while grant=1000 -> grant=0000 on the reset edge. After release, req=1000 -> grant next edge with no turnaround delay; rr_ptr=0, so the search starts at bit 0 and bit 3 wins as the only requester.
- SHARED_LINE_LOCK_EN defined: lock=1, req=0001 held 40 cycles -> no timeout, grant continuous. Drop lock at cycle 40 -> release and timeout pulse on the next edge.

Source files
------------

// File: rtl/shared_line_arbiter_if.sv
// Handshake bundle between the shared-line requesters and the arbiter.
// Optional lock signal appears when SHARED_LINE_LOCK_EN is defined.
interface shared_line_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    owner_id;
    logic             bus_busy;
    logic             timeout;
`ifdef SHARED_LINE_LOCK_EN
    logic             lock;
`endif

    modport master (
        output req,
`ifdef SHARED_LINE_LOCK_EN
        output lock,
`endif
        input  grant,
        input  owner_id,
        input  bus_busy,
        input  timeout
    );

    modport slave (
        input  req,
`ifdef SHARED_LINE_LOCK_EN
        input  lock,
`endif
        output grant,
        output owner_id,
        output bus_busy,
        output timeout
    );
endinterface

// File: rtl/shared_line_arbiter.sv
// Round-robin owner arbiter for one shared tristate line, with turnaround
// gaps and a hold limit. SHARED_LINE_LOCK_EN adds a lock that defers the limit.
module shared_line_arbiter #(
    parameter int N_REQ    = 4,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shared_line_arbiter_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0] MAX_H  = 8'(MAX_HOLD);
    localparam logic [2:0] TURN_C = 3'(TURN_CYC);

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [7:0]       hold_q, hold_d;
    logic [2:0]       turn_q, turn_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic             busy_q, busy_d;
    logic             tmo_q, tmo_d;

    logic             found;
    logic [IW-1:0]    win;
    logic [IW:0]      sum;
    logic [IW-1:0]    nxt_ptr;
    logic             lock_act;
    logic             own_req;
    logic             at_limit;

`ifdef SHARED_LINE_LOCK_EN
    assign lock_act = bus.lock;
`else
    assign lock_act = 1'b0;
`endif

    // First set request at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, rr_ptr_q} + (IW+1)'(i);
            if (sum >= (IW+1)'(N_REQ)) begin
                sum = sum - (IW+1)'(N_REQ);
            end
            if (!found && bus.req[sum[IW-1:0]]) begin
                found = 1'b1;
                win   = sum[IW-1:0];
            end
        end
    end

    assign nxt_ptr  = (owner_q == IW'(N_REQ-1)) ? '0 : owner_q + IW'(1);
    assign own_req  = bus.req[owner_q];
    assign at_limit = (hold_q == MAX_H);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        turn_d   = turn_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        busy_d   = busy_q;
        tmo_d    = 1'b0;
        unique case (state_q)
            IDLE, TURN: begin
                if (state_q == TURN && turn_q < TURN_C) begin
                    turn_d = turn_q + 3'd1;
                end else if (found) begin
                    grant_d = N_REQ'(1) << win;
                    owner_d = win;
                    busy_d  = 1'b1;
                    hold_d  = 8'd1;
                    state_d = OWN;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                if (!own_req || (at_limit && !lock_act)) begin
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    rr_ptr_d = nxt_ptr;
                    turn_d   = 3'd1;
                    tmo_d    = own_req;
                    state_d  = TURN;
                end else if (!at_limit) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            hold_q   <= '0;
            turn_q   <= '0;
            grant_q  <= '0;
            owner_q  <= '0;
            busy_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
            turn_q   <= turn_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
            tmo_q    <= tmo_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.owner_id = owner_q;
    assign bus.bus_busy = busy_q;
    assign bus.timeout  = tmo_q;
endmodule

// File: tb/tb_shared_line_arbiter.sv
// Directed scoreboard bench for shared_line_arbiter (N_REQ=4).
// Covers reset, round-robin, timeout, turnaround length and mid-grant reset.
module tb_shared_line_arbiter;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    shared_line_arbiter_if #(.N_REQ(4)) bus ();
    shared_line_arbiter_if #(.N_REQ(4)) b3 ();

    shared_line_arbiter #(
        .N_REQ(4), .TURN_CYC(1), .MAX_HOLD(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    shared_line_arbiter #(
        .N_REQ(4), .TURN_CYC(3), .MAX_HOLD(16)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(b3.slave)
    );

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] o;
        logic       b;
        logic       t;
    } exp_t;

    exp_t       sbq[$];
    logic [3:0] q3[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] r, input logic [3:0] g,
                       input logic [1:0] o, input logic b,
                       input logic t);
        exp_t e;
        e.g = g;
        e.o = o;
        e.b = b;
        e.t = t;
        bus.req = r;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("grant", {4'b0, bus.grant}, {4'b0, e.g});
        chk("owner_id", {6'b0, bus.owner_id}, {6'b0, e.o});
        chk("bus_busy", {7'b0, bus.bus_busy}, {7'b0, e.b});
        chk("timeout", {7'b0, bus.timeout}, {7'b0, e.t});
        chk("onehot0", {7'b0, $onehot0(bus.grant)}, 8'd1);
    endtask

    task automatic cyc3(input logic [3:0] r, input logic [3:0] g);
        logic [3:0] e;
        b3.req = r;
        q3.push_back(g);
        @(posedge clk);
        #1;
        e = q3.pop_front();
        chk("grant_t3", {4'b0, b3.grant}, {4'b0, e});
        chk("timeout_t3", {7'b0, b3.timeout}, 8'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] bitw;
        int w;
        rst_n   = 1'b0;
        bus.req = '0;
        b3.req  = '0;
`ifdef SHARED_LINE_LOCK_EN
        bus.lock = 1'b0;
        b3.lock  = 1'b0;
`endif
        @(posedge clk);
        #1;
        do_reset();

        // single requester, release, turnaround then idle
        cyc(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        cyc(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        cyc(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
        cyc(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
        cyc(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);

        // round robin with all four requesting
        do_reset();
        for (int k = 0; k < 5; k++) begin
            w    = k % 4;
            bitw = 4'b0001 << w;
            cyc(4'b1111, bitw, 2'(w), 1'b1, 1'b0);
            cyc(4'b1111, bitw, 2'(w), 1'b1, 1'b0);
            cyc(4'b1111 & ~bitw, 4'b0000, 2'(w), 1'b0, 1'b0);
        end

        // hold limit on a sole requester
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        cyc(4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1);
        cyc(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        cyc(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        cyc(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
        cyc(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

        // reset while granted, then immediate regrant
        do_reset();
        cyc(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
        cyc(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
        rst_n = 1'b0;
        cyc(4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
        cyc(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);

        // three-cycle turnaround instance
        do_reset();
        cyc3(4'b0011, 4'b0001);
        cyc3(4'b0010, 4'b0000);
        cyc3(4'b0010, 4'b0000);
        cyc3(4'b0010, 4'b0000);
        cyc3(4'b0010, 4'b0010);
        cyc3(4'b0000, 4'b0000);

`ifdef SHARED_LINE_LOCK_EN
        do_reset();
        bus.lock = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        bus.lock = 1'b0;
        cyc(4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1);
        cyc(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        cyc(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
